fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Decoupled instruction-fetch stage for the pipelined core. It owns the fetch PC and drives the
//  asynchronous-read instruction memory. Fetched {pc, instr} pairs go into a parametrised prefetch
//  FIFO, drained by decode over a valid/ready handshake. Branch/jump redirects flush the FIFO and
//  restart fetch at a new PC. This replaces the single-cycle PC register in the pipelined core.
// PARAMETERS
//  WIDTH      32     address/instruction width
//  DEPTH      4      prefetch FIFO entries, power of two, >= 2
//  RESET_PC   32'h0  fetch PC after reset
//  PC_STEP    4      byte increment per sequential fetch
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous reset, active-high
//  imem_addr     out  WIDTH  fetch PC to instruction memory (combinational read)
//  imem_instr    in   WIDTH  instruction at imem_addr, same cycle
//  redirect_en   in   1      taken branch/jump: flush and refetch
//  redirect_pc   in   WIDTH  new fetch PC; bits [1:0] are forced to 0
//  out_valid     out  1      FIFO head is valid
//  out_ready     in   1      decode accepts head this cycle
//  out_pc        out  WIDTH  PC of head entry
//  out_instr     out  WIDTH  instruction of head entry
//  out_pc_plus4  out  WIDTH  out_pc + PC_STEP (link value for JAL/JALR)
//  occupancy     out  $clog2(DEPTH+1)  current entry count
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, rd/wr pointers=0, occupancy=0, out_valid=0, out_pc/instr=0.
//  - imem_addr = fetch_pc at all times.
//  - pop = out_valid & out_ready.
//  - push = !redirect_en & (occupancy<DEPTH | pop).
//  - On push: write {fetch_pc, imem_instr}, then fetch_pc += PC_STEP (mod 2^WIDTH).
//  - When not pushing and not redirecting, fetch_pc holds.
//  - Latency: an entry pushed in cycle N is visible at out_* in cycle N+1. No combinational
//    path from out_ready to out_valid.
//  - Full FIFO with pop: push and pop both occur; occupancy unchanged.
//  - Empty FIFO: out_valid=0, out_* hold last head value, and out_ready is ignored.
//  - Redirect in cycle N (highest priority, except reset):
//    - occupancy=0 and pointers=0 at N+1.
//    - fetch_pc=redirect_pc&~3 at N+1.
//    - No push in cycle N.
//    - A pop in cycle N is still counted as accepted by decode.
//    - out_valid=0 at N+1; the first redirected entry is at out_* at N+2.
//  - Back-to-back redirects: the last one wins, and no entries are pushed in between.
//  - Pointers are $clog2(DEPTH) wide and wrap naturally; occupancy is a separate counter.
//  - rst asserted mid-stream overrides everything and restores the reset state next cycle.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//    - Adds output fetch_count (32b): pushes since reset.
//    - Adds output flush_count (32b): entries discarded by redirect; adds occupancy minus pop
//      at the redirect cycle.
//    - Adds output stall_cycles (32b): cycles with occupancy==DEPTH and no pop.
//    - All three counters saturate at all-ones and reset to 0.
//  FETCH_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  - fetch_pkg:
//    - typedef fetch_entry_t {logic [WIDTH-1:0] pc; logic [WIDTH-1:0] instr;}
//    - localparam PC_STEP_DEFAULT=4
//    - localparam NOP_INSTR=32'h00000013 (optional decode bubble fill)
//  - Sub-module sync_fifo:
//    - Parametrised DEPTH and element type; synchronous flush.
//    - push/pop/full/empty/count interface.
//    - fetch_queue instantiates it and keeps the PC and redirect logic.
// TESTING
//  1. Reset with RESET_PC=0 -> imem_addr=0, out_valid=0, occupancy=0; first entry at the 2nd cycle
//     after rst drops.
//  2. out_ready=1 constantly -> out_pc sequence 0x0,0x4,0x8,0xC; out_instr matches ROM;
//     out_pc_plus4=out_pc+4.
//  3. out_ready=0, DEPTH=4 -> occupancy reaches 4, imem_addr holds 0x10; then one ready cycle ->
//     pop 0x0 and push 0x10 in the same cycle, occupancy stays 4.
//  4. Redirect to 0x103 while full -> next cycle occupancy=0, out_valid=0, imem_addr=0x100;
//     the following cycle out_pc=0x100.
//  5. Redirects in 2 consecutive cycles (0x200, 0x300) -> no 0x200 entry is ever presented;
//     first out_pc=0x300.
//  6. rst pulse mid-stream with 3 entries -> state restored to scenario 1.
//     With FETCH_PERF_EN, flush_count accumulates 3 per flush of 3 entries.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int PC_STEP_DEFAULT = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered head output and synchronous flush
//   clk, rst        clock, synchronous active-high reset
//   flush           empties the FIFO (pointers and count to 0), head output holds
//   push, din       write request and data (accepted when not full or popping)
//   pop             read request (ignored when empty)
//   dout            head entry, updated one cycle after the push that fills it
//   full, empty     status flags
//   count           current entry count
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type T = fetch_entry_t,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    T mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_pop, do_push;
    logic [CW-1:0] left;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign left = count - CW'(do_pop);
    always_ff @(posedge clk)
        if (!rst && !flush && do_push) mem[wr] <= din;
    // dout is a register so that the head holds its last value when the FIFO drains
    // or is flushed; an entry landing in an empty FIFO bypasses straight into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
            dout <= '0;
        end else if (flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + AW'(1);
            rd <= rd + AW'(do_pop);
            count <= left + CW'(do_push);
            if (left != '0) dout <= mem[rd + AW'(do_pop)];
            else if (do_push) dout <= din;
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled fetch stage owning the fetch PC, feeding a prefetch FIFO to decode
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr, imem_instr    combinational instruction-memory read port
//   redirect_en, redirect_pc flush and restart fetch at redirect_pc with bits [1:0] cleared
//   out_valid, out_ready     decode handshake on the FIFO head
//   out_pc, out_instr        head entry
//   out_pc_plus4             out_pc + PC_STEP (link value)
//   occupancy                FIFO entry count
//   Macro FETCH_PERF_EN adds saturating counters fetch_count, flush_count, stall_cycles.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int PC_STEP = PC_STEP_DEFAULT,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_instr,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc_plus4,
    output logic [CW-1:0]    occupancy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      fetch_count,
    output logic [31:0]      flush_count,
    output logic [31:0]      stall_cycles
`endif
);
    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;
    logic [WIDTH-1:0] fetch_pc;
    logic pop, push, full, empty;
    entry_t din, head;
    assign imem_addr = fetch_pc;
    assign out_valid = !empty;
    assign pop = out_valid & out_ready;
    assign push = !redirect_en & (!full | pop);
    assign din = '{pc: fetch_pc, instr: imem_instr};
    assign out_pc = head.pc;
    assign out_instr = head.instr;
    assign out_pc_plus4 = head.pc + WIDTH'(PC_STEP);
    always_ff @(posedge clk) begin
        if (rst) fetch_pc <= RESET_PC;
        else if (redirect_en) fetch_pc <= redirect_pc & ~WIDTH'(3);
        else if (push) fetch_pc <= fetch_pc + WIDTH'(PC_STEP);
    end
    sync_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect_en),
        .push(push),
        .pop(pop),
        .din(din),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(occupancy)
    );
`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? '1 : s[31:0];
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
            stall_cycles <= '0;
        end else begin
            fetch_count <= sat_add(fetch_count, CW'(push));
            // a pop in the redirect cycle was accepted by decode, so it is not discarded
            if (redirect_en) flush_count <= sat_add(flush_count, occupancy - CW'(pop));
            stall_cycles <= sat_add(stall_cycles, CW'(full & !pop));
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based model
module tb_fetch_queue;
    localparam int D = 4;
    logic clk = 0, rst = 1, redirect_en = 0, out_ready = 0;
    logic [31:0] imem_addr, imem_instr, redirect_pc = '0, out_pc, out_instr, out_pc_plus4;
    logic out_valid;
    logic [2:0] occupancy;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, flush_count, stall_cycles, fl0;
    logic [31:0] m_fetch, m_flush, m_stall;
`endif
    int checks = 0, errors = 0;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t q[$];
    ent_t e;
    logic [31:0] m_pc, h_pc, h_instr;

    fetch_queue #(.WIDTH(32), .DEPTH(D), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_pc_plus4(out_pc_plus4), .occupancy(occupancy)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .flush_count(flush_count), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction
    assign imem_instr = rom(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = 0;
        h_pc = 0;
        h_instr = 0;
`ifdef FETCH_PERF_EN
        m_fetch = 0;
        m_flush = 0;
        m_stall = 0;
`endif
    endtask

    // one clock: apply inputs at the falling edge, compare against the model, advance the model
    task automatic cycle(input logic r, input logic re, input logic [31:0] rpc, input logic rdy);
        bit pop;
        int n;
        rst = r;
        redirect_en = re;
        redirect_pc = rpc;
        out_ready = rdy;
        #1;
        n = q.size();
        check("out_valid", 32'(out_valid), 32'(n > 0));
        check("occupancy", 32'(occupancy), 32'(n));
        check("imem_addr", imem_addr, m_pc);
        check("out_pc", out_pc, n > 0 ? q[0].pc : h_pc);
        check("out_instr", out_instr, n > 0 ? q[0].instr : h_instr);
        check("out_pc_plus4", out_pc_plus4, (n > 0 ? q[0].pc : h_pc) + 32'd4);
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, m_fetch);
        check("flush_count", flush_count, m_flush);
        check("stall_cycles", stall_cycles, m_stall);
`endif
        pop = n > 0 && rdy;
        if (r) model_reset();
        else begin
`ifdef FETCH_PERF_EN
            if (n == D && !pop) m_stall++;
            if (re) m_flush += 32'(n - int'(pop));
`endif
            if (pop) void'(q.pop_front());
            if (re) begin
                q.delete();
                m_pc = rpc & ~32'd3;
            end else if (n < D || pop) begin
                e.pc = m_pc;
                e.instr = rom(m_pc);
                q.push_back(e);
                m_pc += 4;
`ifdef FETCH_PERF_EN
                m_fetch++;
`endif
            end
            if (q.size() > 0) begin
                h_pc = q[0].pc;
                h_instr = q[0].instr;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        // reset state and streaming with decode always ready
        cycle(0, 0, 0, 1);
        check("t1_valid_2nd", 32'(out_valid), 1);
        check("t1_first_pc", out_pc, 0);
        repeat (6) cycle(0, 0, 0, 1);
        // fill with decode stalled, then a single pop/push cycle
        cycle(1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0);
        check("t3_full_occ", 32'(occupancy), 4);
        check("t3_addr_hold", imem_addr, 32'h10);
        cycle(0, 0, 0, 1);
        check("t3_occ_same", 32'(occupancy), 4);
        check("t3_head_after_pop", out_pc, 32'h4);
        check("t3_addr_after", imem_addr, 32'h14);
        // redirect while full
        cycle(0, 1, 32'h103, 0);
        check("t4_occ0", 32'(occupancy), 0);
        check("t4_valid0", 32'(out_valid), 0);
        check("t4_addr", imem_addr, 32'h100);
        cycle(0, 0, 0, 0);
        check("t4_pc", out_pc, 32'h100);
        // back-to-back redirects
        cycle(0, 1, 32'h200, 1);
        cycle(0, 1, 32'h300, 1);
        check("t5_addr", imem_addr, 32'h300);
        cycle(0, 0, 0, 1);
        check("t5_first_pc", out_pc, 32'h300);
        repeat (4) cycle(0, 0, 0, 1);
        // three entries, flush them, refill, then reset mid-stream
        cycle(0, 1, 32'h400, 0);
        repeat (3) cycle(0, 0, 0, 0);
        check("t6_occ3", 32'(occupancy), 3);
`ifdef FETCH_PERF_EN
        fl0 = flush_count;
        cycle(0, 1, 32'h500, 0);
        check("t6_flush3", flush_count - fl0, 3);
        repeat (3) cycle(0, 0, 0, 0);
`endif
        cycle(1, 0, 0, 1);
        check("t6_addr", imem_addr, 0);
        check("t6_valid", 32'(out_valid), 0);
        check("t6_occ", 32'(occupancy), 0);
        check("t6_pc", out_pc, 0);
        cycle(0, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom,
                  i < 300 ? $urandom_range(3) == 0 : $urandom_range(3) != 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
